// File: rtl/isp_cis_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : isp_cis_pkg
// Desc   : Shared types and default widths for the CIS capture front-end.
// Rev    : 1.0
// ============================================================================
package isp_cis_pkg;

    localparam int c_data_w      = 10;
    localparam int c_sync_stages = 2;
    localparam int c_fifo_depth  = 16;
    localparam int c_cnt_w       = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2,
        DROP    = 2'd3
    } cis_state_e;

    typedef struct packed {
        logic                sof;
        logic                eol;
        logic [c_data_w-1:0] data;
    } cis_entry_t;

endpackage
`default_nettype wire

// File: rtl/cis_pix_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : cis_pix_fifo
// Desc   : First-word-fall-through synchronous FIFO, head visible when !empty.
// Rev    : 1.0
// ============================================================================
module cis_pix_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int c_addr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_addr_w:0] r_wr_ptr;
    logic [c_addr_w:0] r_rd_ptr;
    logic              w_wr;
    logic              w_rd;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                   (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign w_rd  = pop & ~empty;
    assign w_wr  = push & (~full | w_rd);
    assign head  = r_mem[r_rd_ptr[c_addr_w-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + (c_addr_w+1)'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + (c_addr_w+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[c_addr_w-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/cis_dvp_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : cis_dvp_capture
// Desc   : DVP sensor capture: resync, framing (sof/eol), FIFO, status.
// Rev    : 1.0
// ============================================================================
module cis_dvp_capture
    import isp_cis_pkg::*;
#(
    parameter int DATA_W      = c_data_w,
    parameter int SYNC_STAGES = c_sync_stages,
    parameter int FIFO_DEPTH  = c_fifo_depth,
    parameter int CNT_W       = c_cnt_w
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              enable,
    input  logic              cis_pclk,
    input  logic              cis_hsync,
    input  logic              cis_vsync,
    input  logic [DATA_W-1:0] cis_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  line_cnt,
    output logic [CNT_W-1:0]  last_line_len,
    output logic [CNT_W-1:0]  ovf_cnt,
    output logic              ovf_pulse
);
    localparam int c_in_w  = DATA_W + 3;
    localparam int c_ent_w = DATA_W + 2;

    logic [c_in_w-1:0]  r_sync [SYNC_STAGES];
    logic               r_pclk_d;
    logic               r_vs_d;
    logic               r_hs_last;
    cis_state_e         r_state;
    cis_state_e         w_state_nxt;
    logic               r_stg_valid;
    logic [DATA_W-1:0]  r_stg_data;
    logic               r_sof_pending;
    logic [CNT_W-1:0]   r_line_pix;
    logic [CNT_W-1:0]   r_line_cnt;
    logic [CNT_W-1:0]   r_last_len;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CNT_W-1:0]   r_ovf_cnt;
    logic               r_ovf_pulse;

    logic               w_s_pclk, w_s_hs, w_s_vs;
    logic [DATA_W-1:0]  w_s_data;
    logic               w_pclk_rise, w_vs_rise, w_vs_fall, w_hs_fall, w_pix;
    logic               w_push, w_push_eol, w_stg_load, w_line_done;
    logic               w_frame_done, w_arm, w_ovf;
    logic [1:0]         w_drop_inc;
    logic [CNT_W:0]     w_ovf_sum;
    logic               w_fifo_full, w_fifo_empty, w_pop;
    logic [c_ent_w-1:0] w_head;

    // All sensor lines share one chain so pclk, syncs and data stay aligned.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= {cis_pclk, cis_hsync, cis_vsync, cis_data};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign {w_s_pclk, w_s_hs, w_s_vs, w_s_data} = r_sync[SYNC_STAGES-1];
    assign w_pclk_rise = w_s_pclk & ~r_pclk_d;
    assign w_vs_rise   = w_s_vs & ~r_vs_d;
    assign w_vs_fall   = ~w_s_vs & r_vs_d;
    assign w_hs_fall   = w_pclk_rise & r_hs_last & ~w_s_hs;
    assign w_pix       = w_pclk_rise & w_s_hs;
    assign w_pop       = out_valid & out_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_push       = 1'b0;
        w_push_eol   = 1'b0;
        w_stg_load   = 1'b0;
        w_line_done  = 1'b0;
        w_frame_done = 1'b0;
        w_arm        = 1'b0;
        w_ovf        = 1'b0;
        w_drop_inc   = 2'd0;
        case (r_state)
            IDLE: begin
                if (enable) w_state_nxt = WAIT_VS;
            end
            WAIT_VS: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end else if (w_vs_fall) begin
                    w_state_nxt = ACTIVE;
                    w_arm       = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_vs_rise) begin
                    w_push       = r_stg_valid;
                    w_push_eol   = 1'b1;
                    w_line_done  = r_stg_valid;
                    w_frame_done = 1'b1;
                    w_state_nxt  = enable ? WAIT_VS : IDLE;
                end else if (w_hs_fall) begin
                    w_push      = r_stg_valid;
                    w_push_eol  = 1'b1;
                    w_line_done = r_stg_valid;
                end else if (w_pix) begin
                    w_push     = r_stg_valid;
                    w_stg_load = 1'b1;
                end
                // A blocked push also discards the pixel arriving with it.
                if (w_push && w_fifo_full && !w_pop) begin
                    w_ovf        = 1'b1;
                    w_frame_done = 1'b0;
                    w_drop_inc   = w_stg_load ? 2'd2 : 2'd1;
                    if (!w_vs_rise) w_state_nxt = DROP;
                end
            end
            DROP: begin
                if (w_vs_rise) begin
                    w_state_nxt = enable ? WAIT_VS : IDLE;
                end else if (w_pix) begin
                    w_drop_inc = 2'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_ovf_sum = {1'b0, r_ovf_cnt} + {{(CNT_W-1){1'b0}}, w_drop_inc};

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state       <= IDLE;
            r_pclk_d      <= 1'b0;
            r_vs_d        <= 1'b0;
            r_hs_last     <= 1'b0;
            r_stg_valid   <= 1'b0;
            r_stg_data    <= '0;
            r_sof_pending <= 1'b0;
            r_line_pix    <= '0;
            r_line_cnt    <= '0;
            r_last_len    <= '0;
            r_frame_cnt   <= '0;
            r_ovf_cnt     <= '0;
            r_ovf_pulse   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pclk_d <= w_s_pclk;
            r_vs_d   <= w_s_vs;
            if (w_pclk_rise) r_hs_last <= w_s_hs;

            if (w_arm || w_ovf)   r_stg_valid <= 1'b0;
            else if (w_stg_load)  r_stg_valid <= 1'b1;
            else if (w_push)      r_stg_valid <= 1'b0;
            if (w_stg_load) r_stg_data <= w_s_data;

            if (w_arm)       r_sof_pending <= 1'b1;
            else if (w_push) r_sof_pending <= 1'b0;

            if (w_arm || w_line_done) r_line_pix <= '0;
            else if (w_stg_load)      r_line_pix <= r_line_pix + CNT_W'(1);

            if (w_arm)            r_line_cnt <= '0;
            else if (w_line_done) r_line_cnt <= r_line_cnt + CNT_W'(1);
            if (w_line_done)      r_last_len <= r_line_pix;

            if (w_frame_done) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            r_ovf_cnt   <= w_ovf_sum[CNT_W] ? '1 : w_ovf_sum[CNT_W-1:0];
            r_ovf_pulse <= w_ovf;
        end
    end

    cis_pix_fifo #(
        .WIDTH (c_ent_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_n),
        .push      (w_push & ~w_ovf),
        .push_data ({r_sof_pending, w_push_eol, r_stg_data}),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign out_valid     = ~w_fifo_empty;
    assign out_data      = out_valid ? w_head[DATA_W-1:0] : '0;
    assign out_eol       = out_valid & w_head[DATA_W];
    assign out_sof       = out_valid & w_head[DATA_W+1];
    assign busy          = (r_state != IDLE);
    assign frame_cnt     = r_frame_cnt;
    assign line_cnt      = r_line_cnt;
    assign last_line_len = r_last_len;
    assign ovf_cnt       = r_ovf_cnt;
    assign ovf_pulse     = r_ovf_pulse;

endmodule
`default_nettype wire

// File: tb/tb_cis_dvp_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_cis_dvp_capture
// Desc   : Scoreboard bench for cis_dvp_capture with a frame-level model.
// Rev    : 1.0
// ============================================================================
module tb_cis_dvp_capture;
    localparam int DATA_W      = 10;
    localparam int SYNC_STAGES = 2;
    localparam int FIFO_DEPTH  = 16;
    localparam int CNT_W       = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, enable, cis_pclk, cis_hsync, cis_vsync;
    logic [DATA_W-1:0] cis_data;
    logic              out_valid, out_ready, out_sof, out_eol, busy, ovf_pulse;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  frame_cnt, line_cnt, last_line_len, ovf_cnt;

    typedef struct packed {
        logic              sof;
        logic              eol;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    beat_t held;
    logic  stalled = 1'b0;
    int    checks = 0, errors = 0;
    int    ready_mode = 0;
    int    n_pulse = 0;
    int    exp_frames = 0, exp_ovf = 0;
    int    ln[8];

    cis_dvp_capture #(
        .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .enable(enable),
        .cis_pclk(cis_pclk), .cis_hsync(cis_hsync), .cis_vsync(cis_vsync), .cis_data(cis_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol), .busy(busy),
        .frame_cnt(frame_cnt), .line_cnt(line_cnt), .last_line_len(last_line_len),
        .ovf_cnt(ovf_cnt), .ovf_pulse(ovf_pulse)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Ready changes just after the edge so it is settled at the sampling point.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_beat", 32'({out_sof, out_eol, out_data}), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: actual 0x%0h required no beat",
                             {out_sof, out_eol, out_data});
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat", 32'({out_sof, out_eol, out_data}), 32'(mon_e));
                end
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                held    = {out_sof, out_eol, out_data};
            end else begin
                stalled = 1'b0;
            end
            if (ovf_pulse) n_pulse++;
        end
    end

    task automatic pix(input logic hs, input logic [DATA_W-1:0] d);
        @(negedge clk);
        cis_pclk  = 1'b0;
        cis_hsync = hs;
        cis_data  = d;
        @(negedge clk);
        @(negedge clk);
        cis_pclk = 1'b1;
        @(negedge clk);
    endtask

    // Frame of nl lines (lengths in ln[]); the first cap pixels are expected out.
    task automatic send_frame(input int nl, input bit seq, input bit flush_end, input int cap);
        int                k;
        logic [DATA_W-1:0] d;
        beat_t             b;
        k = 0;
        cis_vsync = 1'b1;
        repeat (3) pix(1'b0, '0);
        cis_vsync = 1'b0;
        repeat (2) pix(1'b0, '0);
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < ln[l]; p++) begin
                k++;
                d = seq ? DATA_W'(k) : DATA_W'($urandom);
                if (k <= cap) begin
                    b.sof  = (k == 1);
                    b.eol  = (p == ln[l] - 1);
                    b.data = d;
                    exp_q.push_back(b);
                end
                pix(1'b1, d);
            end
            if (!(flush_end && l == nl - 1)) repeat (2) pix(1'b0, '0);
        end
        if (k > cap && cap > 0) exp_ovf += k - cap;
        cis_vsync = 1'b1;
        repeat (3) pix(flush_end, '0);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: actual %0d beats missing required 0", name, exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_stats(input string name, input int nl, input int last_len);
        check({name, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
        check({name, "_line_cnt"}, 32'(line_cnt), 32'(nl));
        check({name, "_last_len"}, 32'(last_line_len), 32'(last_len));
        check({name, "_ovf_cnt"}, 32'(ovf_cnt), 32'(exp_ovf));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: actual still running required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nl;
        bit fl;
        rst_n = 1'b0; enable = 1'b0;
        cis_pclk = 1'b0; cis_hsync = 1'b0; cis_vsync = 1'b0; cis_data = '0;
        repeat (3) @(negedge clk);
        check("reset_flags", 32'({out_valid, out_sof, out_eol, busy, ovf_pulse}), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);
        check("reset_cnt_a", 32'({frame_cnt, line_cnt}), 32'd0);
        check("reset_cnt_b", 32'({last_line_len, ovf_cnt}), 32'd0);
        rst_n = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_enabled", 32'(busy), 32'd1);

        // Basic 2x4 frame, data 1..8
        ln[0] = 4; ln[1] = 4;
        send_frame(2, 1'b1, 1'b0, 1000);
        exp_frames++;
        check_stats("basic", 2, 4);
        drain("basic");

        // Backpressure for 12 cycles mid-line
        fork
            send_frame(2, 1'b1, 1'b0, 1000);
            begin
                repeat (40) @(negedge clk);
                ready_mode = 2;
                repeat (12) @(negedge clk);
                ready_mode = 0;
            end
        join
        exp_frames++;
        check_stats("bp", 2, 4);
        drain("bp");

        // Single-pixel line, then a frame whose last pixel is flushed by vs_rise
        ln[0] = 1; ln[1] = 3;
        send_frame(2, 1'b0, 1'b0, 1000);
        exp_frames++;
        check_stats("one_pix", 2, 3);
        drain("one_pix");
        ln[0] = 2; ln[1] = 3;
        send_frame(2, 1'b0, 1'b1, 1000);
        exp_frames++;
        check("flush_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        drain("flush");

        // Overflow: 1x20 frame with the stream stalled throughout
        ready_mode = 2;
        ln[0] = 20;
        send_frame(1, 1'b1, 1'b0, FIFO_DEPTH);
        check("ovf_cnt", 32'(ovf_cnt), 32'd4);
        check("ovf_pulses", 32'(n_pulse), 32'd1);
        check("ovf_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        check("ovf_busy", 32'(busy), 32'd1);
        ready_mode = 0;
        drain("ovf");
        ln[0] = 3; ln[1] = 2;
        send_frame(2, 1'b0, 1'b0, 1000);
        exp_frames++;
        check_stats("post_ovf", 2, 2);
        drain("post_ovf");

        // Randomised frames under random backpressure
        ready_mode = 1;
        for (int f = 0; f < 6; f++) begin
            nl = $urandom_range(1, 3);
            fl = 1'($urandom_range(0, 1));
            for (int l = 0; l < nl; l++) ln[l] = $urandom_range(1, 5);
            send_frame(nl, 1'b0, fl, 1000);
            exp_frames++;
            if (fl) check("rnd_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
            else    check_stats("rnd", nl, ln[nl-1]);
            drain("rnd");
        end
        ready_mode = 0;

        // Enable drop mid-line: this frame completes, the next is ignored
        ln[0] = 4; ln[1] = 4;
        fork
            send_frame(2, 1'b0, 1'b0, 1000);
            begin
                repeat (30) @(negedge clk);
                enable = 1'b0;
            end
        join
        exp_frames++;
        check("en_busy", 32'(busy), 32'd0);
        check_stats("en_drop", 2, 4);
        drain("en_drop");
        send_frame(2, 1'b0, 1'b0, 0);
        repeat (20) @(negedge clk);
        check("en_idle_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        check("en_idle_busy", 32'(busy), 32'd0);
        enable = 1'b1;

        // Reset during line 1; remainder of that frame must not appear
        ready_mode = 2;
        fork
            send_frame(2, 1'b0, 1'b0, 0);
            begin
                repeat (26) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check("mid_rst_flags", 32'({out_valid, out_sof, out_eol, busy, ovf_pulse}), 32'd0);
                check("mid_rst_data", 32'(out_data), 32'd0);
                check("mid_rst_cnt", 32'({frame_cnt, ovf_cnt}), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        exp_frames = 0;
        exp_ovf    = 0;
        ready_mode = 0;
        repeat (10) @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        ln[0] = 3; ln[1] = 4;
        send_frame(2, 1'b0, 1'b0, 1000);
        exp_frames++;
        check_stats("post_rst", 2, 4);
        drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
